// File: rtl/fwd_types.sv
// Shared types for the forwarding scoreboard: writeback class, shadow entry,
// and the per-class readiness rule.
package fwd_types;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2,
    WB_MUL  = 2'd3
  } wb_class_t;

  typedef struct packed {
    logic      valid;
    logic      we;
    logic [4:0] rd;
    wb_class_t cls;
  } sb_entry_t;

  // True when a result of class cls sitting in the given stage can be bypassed.
  function automatic logic ready_at(input int unsigned stage,
                                    input wb_class_t   cls,
                                    input int unsigned ld_stage,
                                    input int unsigned mul_stage);
    logic rdy;
    rdy = 1'b0;
    case (cls)
      WB_ALU:  rdy = (stage >= 1);
      WB_LOAD: rdy = (stage >= ld_stage);
      WB_MUL:  rdy = (stage >= mul_stage);
      default: rdy = 1'b0;
    endcase
    return rdy;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher for one EX source operand over the tracked stages 1..DEPTH.
// The youngest matching producer wins; if it is not ready yet the source stalls.
module fwd_match
  import fwd_types::*;
#(
  parameter int DEPTH           = 3,
  parameter int LD_READY_STAGE  = 2,
  parameter int MUL_READY_STAGE = 3,
  parameter int SELW            = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH:1] ent_i,
  input  logic [4:0]          src_rs_i,
  input  logic                src_used_i,
  output logic [SELW-1:0]     sel_o,
  output logic                stall_o
);

  logic found;

  always_comb begin
    sel_o   = '0;
    stall_o = 1'b0;
    found   = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!found && src_used_i && ent_i[k].valid && ent_i[k].we &&
          (ent_i[k].rd != 5'd0) && (ent_i[k].rd == src_rs_i)) begin
        found = 1'b1;
        // A not-yet-ready youngest producer must stall even if an older one is ready.
        if (ready_at(k, ent_i[k].cls, LD_READY_STAGE, MUL_READY_STAGE)) begin
          sel_o = SELW'(k);
        end else begin
          stall_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit: shadows the writeback-carrying stages after EX,
// selects bypass sources per EX operand and raises load/mul-use stalls.
module fwd_scoreboard
  import fwd_types::*;
#(
  parameter int NUM_SRC         = 2,
  parameter int DEPTH           = 3,
  parameter int LD_READY_STAGE  = 2,
  parameter int MUL_READY_STAGE = 3,
  parameter int SELW            = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_in,
  input  logic                    flush,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_we,
  input  logic [1:0]              issue_class,
  input  logic [NUM_SRC*5-1:0]    src_rs,
  input  logic [NUM_SRC-1:0]      src_used,
  output logic [NUM_SRC*SELW-1:0] fwd_sel,
  output logic                    fwd_stall,
  output logic [31:0]             stall_cycles
);

  if (NUM_SRC < 1) begin : g_bad_num_src
    $error("fwd_scoreboard: NUM_SRC must be at least 1");
  end
  if (LD_READY_STAGE < 1 || LD_READY_STAGE > DEPTH) begin : g_bad_ld_stage
    $error("fwd_scoreboard: LD_READY_STAGE must lie in 1..DEPTH");
  end
  if (MUL_READY_STAGE < 1 || MUL_READY_STAGE > DEPTH) begin : g_bad_mul_stage
    $error("fwd_scoreboard: MUL_READY_STAGE must lie in 1..DEPTH");
  end

  sb_entry_t [DEPTH:0] entry_q, entry_d;
  logic [NUM_SRC-1:0]  src_stall;
  logic [31:0]         stall_cycles_q, stall_cycles_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .DEPTH           (DEPTH),
      .LD_READY_STAGE  (LD_READY_STAGE),
      .MUL_READY_STAGE (MUL_READY_STAGE),
      .SELW            (SELW)
    ) u_match (
      .ent_i      (entry_q[DEPTH:1]),
      .src_rs_i   (src_rs[5*i +: 5]),
      .src_used_i (src_used[i]),
      .sel_o      (fwd_sel[SELW*i +: SELW]),
      .stall_o    (src_stall[i])
    );
  end

  // A bubble in EX has no operands, so it never stalls.
  assign fwd_stall    = entry_q[0].valid & (|src_stall);
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    entry_d = entry_q;
    if (!stall_in) begin
      for (int k = DEPTH; k >= 1; k--) begin
        entry_d[k] = entry_q[k-1];
      end
      if (fwd_stall) begin
        entry_d[0] = entry_q[0];
        entry_d[1] = '0;
      end else begin
        entry_d[0] = '{valid: issue_valid & ~flush,
                       we:    issue_we,
                       rd:    issue_rd,
                       cls:   wb_class_t'(issue_class)};
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (fwd_stall && !stall_in && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q        <= '0;
      stall_cycles_q <= '0;
    end else begin
      entry_q        <= entry_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: default build plus a DEPTH=5 / LD_READY_STAGE=4 build.
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_we;
  logic [1:0]  issue_class;
  logic [9:0]  src_rs;
  logic [1:0]  src_used;

  logic [3:0]  fwd_sel;
  logic        fwd_stall;
  logic [31:0] stall_cycles;

  logic [5:0]  fwd_sel5;
  logic        fwd_stall5;
  logic [31:0] stall_cycles5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_scoreboard u_dut (
    .clk          (clk),
    .rst          (rst),
    .stall_in     (stall_in),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_we     (issue_we),
    .issue_class  (issue_class),
    .src_rs       (src_rs),
    .src_used     (src_used),
    .fwd_sel      (fwd_sel),
    .fwd_stall    (fwd_stall),
    .stall_cycles (stall_cycles)
  );

  fwd_scoreboard #(
    .NUM_SRC         (2),
    .DEPTH           (5),
    .LD_READY_STAGE  (4),
    .MUL_READY_STAGE (5)
  ) u_dut5 (
    .clk          (clk),
    .rst          (rst),
    .stall_in     (stall_in),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_we     (issue_we),
    .issue_class  (issue_class),
    .src_rs       (src_rs),
    .src_used     (src_used),
    .fwd_sel      (fwd_sel5),
    .fwd_stall    (fwd_stall5),
    .stall_cycles (stall_cycles5)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    stall_in    = 1'b0;
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_we    = 1'b0;
    issue_rd    = 5'd0;
    issue_class = 2'd0;
    src_rs      = '0;
    src_used    = '0;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic [1:0] cls);
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    issue_rd    = rd;
    issue_class = cls;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    checks++;
    if (fwd_sel !== 4'd0) begin
      errors++; $display("FAIL reset_sel: got %0d expected 0", fwd_sel);
    end
    checks++;
    if (fwd_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %0d expected 0", fwd_stall);
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", stall_cycles);
    end
    #3;
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_issue(5'd5, 2'd2);
    step();
    set_issue(5'd6, 2'd1);
    step();
    issue_valid = 1'b0;
    src_rs = {5'd5, 5'd5};
    src_used = 2'b11;
    #1;
    checks++;
    if (fwd_stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall: got %0d expected 1", fwd_stall);
    end
    checks++;
    if (fwd_sel !== 4'd0) begin
      errors++; $display("FAIL lu_sel_stalled: got %0d expected 0", fwd_sel);
    end
    step();
    checks++;
    if (stall_cycles !== 32'd1) begin
      errors++; $display("FAIL lu_count: got %0d expected 1", stall_cycles);
    end
    checks++;
    if (fwd_stall !== 1'b0) begin
      errors++; $display("FAIL lu_release: got %0d expected 0", fwd_stall);
    end
    checks++;
    if (fwd_sel !== 4'b1010) begin
      errors++; $display("FAIL lu_sel: got %0d expected 10", fwd_sel);
    end
  endtask

  task automatic test_youngest();
    do_reset();
    set_issue(5'd3, 2'd1);
    step();
    set_issue(5'd3, 2'd1);
    step();
    set_issue(5'd10, 2'd1);
    step();
    issue_valid = 1'b0;
    src_rs = {5'd0, 5'd3};
    src_used = 2'b01;
    #1;
    checks++;
    if (fwd_sel !== 4'b0001 || fwd_stall !== 1'b0) begin
      errors++; $display("FAIL young_alu: got sel=%0d stall=%0d expected sel=1 stall=0", fwd_sel, fwd_stall);
    end
    do_reset();
    set_issue(5'd3, 2'd1);
    step();
    set_issue(5'd3, 2'd2);
    step();
    set_issue(5'd10, 2'd1);
    step();
    issue_valid = 1'b0;
    src_rs = {5'd0, 5'd3};
    src_used = 2'b01;
    #1;
    checks++;
    if (fwd_stall !== 1'b1 || fwd_sel !== 4'd0) begin
      errors++; $display("FAIL young_load: got sel=%0d stall=%0d expected sel=0 stall=1", fwd_sel, fwd_stall);
    end
  endtask

  task automatic test_x0_unused();
    do_reset();
    set_issue(5'd0, 2'd1);
    step();
    set_issue(5'd10, 2'd1);
    step();
    issue_valid = 1'b0;
    src_rs = {5'd0, 5'd0};
    src_used = 2'b11;
    #1;
    checks++;
    if (fwd_sel !== 4'd0 || fwd_stall !== 1'b0) begin
      errors++; $display("FAIL x0: got sel=%0d stall=%0d expected sel=0 stall=0", fwd_sel, fwd_stall);
    end
    do_reset();
    set_issue(5'd7, 2'd2);
    step();
    set_issue(5'd10, 2'd1);
    step();
    issue_valid = 1'b0;
    src_rs = {5'd7, 5'd7};
    src_used = 2'b00;
    #1;
    checks++;
    if (fwd_stall !== 1'b0) begin
      errors++; $display("FAIL unused: got %0d expected 0", fwd_stall);
    end
    src_used = 2'b10;
    #1;
    checks++;
    if (fwd_stall !== 1'b1) begin
      errors++; $display("FAIL src1_used: got %0d expected 1", fwd_stall);
    end
  endtask

  task automatic test_mul();
    do_reset();
    set_issue(5'd9, 2'd3);
    step();
    set_issue(5'd11, 2'd1);
    step();
    issue_valid = 1'b0;
    src_rs = {5'd0, 5'd9};
    src_used = 2'b01;
    #1;
    checks++;
    if (fwd_stall !== 1'b1) begin
      errors++; $display("FAIL mul_s1: got %0d expected 1", fwd_stall);
    end
    step();
    checks++;
    if (fwd_stall !== 1'b1 || stall_cycles !== 32'd1) begin
      errors++; $display("FAIL mul_s2: got stall=%0d cnt=%0d expected stall=1 cnt=1", fwd_stall, stall_cycles);
    end
    step();
    checks++;
    if (fwd_stall !== 1'b0 || fwd_sel !== 4'b0011) begin
      errors++; $display("FAIL mul_fwd: got stall=%0d sel=%0d expected stall=0 sel=3", fwd_stall, fwd_sel);
    end
    checks++;
    if (stall_cycles !== 32'd2) begin
      errors++; $display("FAIL mul_count: got %0d expected 2", stall_cycles);
    end
  endtask

  task automatic test_stall_in_flush();
    do_reset();
    set_issue(5'd5, 2'd2);
    step();
    set_issue(5'd6, 2'd1);
    step();
    issue_valid = 1'b0;
    src_rs = {5'd5, 5'd5};
    src_used = 2'b11;
    stall_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (fwd_stall !== 1'b1 || stall_cycles !== 32'd0) begin
        errors++; $display("FAIL frz_%0d: got stall=%0d cnt=%0d expected stall=1 cnt=0", c, fwd_stall, stall_cycles);
      end
    end
    stall_in = 1'b0;
    step();
    checks++;
    if (stall_cycles !== 32'd1 || fwd_stall !== 1'b0 || fwd_sel !== 4'b1010) begin
      errors++; $display("FAIL frz_release: got cnt=%0d stall=%0d sel=%0d expected 1 0 10", stall_cycles, fwd_stall, fwd_sel);
    end
    src_used = 2'b00;
    set_issue(5'd8, 2'd2);
    step();
    flush = 1'b1;
    set_issue(5'd12, 2'd1);
    src_rs = {5'd8, 5'd8};
    src_used = 2'b11;
    step();
    flush = 1'b0;
    issue_valid = 1'b0;
    #1;
    checks++;
    if (fwd_stall !== 1'b0 || fwd_sel !== 4'd0) begin
      errors++; $display("FAIL flush_bubble: got stall=%0d sel=%0d expected 0 0", fwd_stall, fwd_sel);
    end
    checks++;
    if (stall_cycles !== 32'd1) begin
      errors++; $display("FAIL flush_count: got %0d expected 1", stall_cycles);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_issue(5'd9, 2'd3);
    step();
    set_issue(5'd11, 2'd1);
    step();
    issue_valid = 1'b0;
    src_rs = {5'd0, 5'd9};
    src_used = 2'b01;
    step();
    checks++;
    if (fwd_stall !== 1'b1 || stall_cycles !== 32'd1) begin
      errors++; $display("FAIL ar_pre: got stall=%0d cnt=%0d expected 1 1", fwd_stall, stall_cycles);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fwd_stall !== 1'b0 || stall_cycles !== 32'd0 || fwd_sel !== 4'd0) begin
      errors++; $display("FAIL ar_clear: got stall=%0d cnt=%0d sel=%0d expected 0 0 0", fwd_stall, stall_cycles, fwd_sel);
    end
    #2;
    rst = 1'b1;
  endtask

  task automatic test_depth5_sweep();
    do_reset();
    set_issue(5'd5, 2'd2);
    step();
    set_issue(5'd6, 2'd1);
    step();
    issue_valid = 1'b0;
    src_rs = {5'd5, 5'd5};
    src_used = 2'b11;
    #1;
    checks++;
    if (fwd_stall5 !== 1'b1) begin
      errors++; $display("FAIL d5_s1: got %0d expected 1", fwd_stall5);
    end
    for (int c = 2; c <= 3; c++) begin
      step();
      checks++;
      if (fwd_stall5 !== 1'b1) begin
        errors++; $display("FAIL d5_s%0d: got %0d expected 1", c, fwd_stall5);
      end
    end
    step();
    checks++;
    if (fwd_stall5 !== 1'b0 || fwd_sel5 !== 6'b100100) begin
      errors++; $display("FAIL d5_fwd: got stall=%0d sel=%0d expected stall=0 sel=36", fwd_stall5, fwd_sel5);
    end
    checks++;
    if (stall_cycles5 !== 32'd3) begin
      errors++; $display("FAIL d5_count: got %0d expected 3", stall_cycles5);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_youngest();
    test_x0_unused();
    test_mul();
    test_stall_in_flush();
    test_async_reset();
    test_depth5_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the deeper in-order rv32i pipeline.
- Keeps its own shift-register shadow of the DEPTH writeback-carrying stages downstream of EX, tagged with result class (ALU/LOAD/MUL).
- Per EX source operand, emits the youngest ready bypass stage, or a load-use/mul-use stall that freezes EX and bubbles EX/MEM.
- Never forwards x0; counts stall cycles.

Parameters:
NUM_SRC, 2, source operands checked in EX (rs1, rs2, ...)
DEPTH, 3, tracked stages after EX (1 = EX/MEM ... DEPTH = last stage before regfile write)
LD_READY_STAGE, 2, first stage at which a LOAD result is forwardable
MUL_READY_STAGE, 3, first stage at which a MUL result is forwardable
SELW, $clog2(DEPTH+1), width of each forward select

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
stall_in  in  1  global pipeline freeze (cache miss); every tracked stage holds
flush  in  1  branch/jump redirect resolved in EX; incoming issue is discarded
issue_valid  in  1  ID/EX register loads a new instruction this cycle
issue_rd  in  5  destination of issuing instruction
issue_we  in  1  issuing instruction writes the regfile
issue_class  in  2  wb_class_t of issuing instruction
src_rs  in  NUM_SRC*5  EX source register indices, source i at [5i+4:5i]
src_used  in  NUM_SRC  source i actually read by the EX instruction
fwd_sel  out  NUM_SRC*SELW  per source: 0 = regfile/ID-EX value, k = bypass from stage k
fwd_stall  out  1  hold EX and ID/EX, insert bubble into stage 1
stall_cycles  out  32  saturating count of cycles fwd_stall caused a bubble

Behaviour:
- State: entry[0..DEPTH], each {valid, we, rd[4:0], cls}. entry[0] mirrors the instruction in EX.
- Reset (rst low, async): all entries invalid, stall_cycles = 0. Hence fwd_sel = 0 and fwd_stall = 0 immediately.
- Match, combinational, per source i:
  - hit(k) = entry[k].valid & entry[k].we & entry[k].rd != 0 & entry[k].rd == src_rs[i] & src_used[i], for k in 1..DEPTH.
  - The winner is the smallest k with hit(k), i.e. the youngest producer.
  - ready(k, cls):
    - ALU: k >= 1
    - LOAD: k >= LD_READY_STAGE
    - MUL: k >= MUL_READY_STAGE
    - NONE: never written (we must be 0 for NONE).
  - Winner ready: fwd_sel[i] = k.
  - Winner not ready: fwd_sel[i] = 0 and src_stall[i] = 1.
  - No winner: fwd_sel[i] = 0.
  - An older ready match never masks a younger non-ready one.
- fwd_stall = entry[0].valid & OR(src_stall). No stall is raised when entry[0] is a bubble.
- Update at posedge clk, priority order:
  1. stall_in = 1: all entries hold. flush and issue_valid are ignored; the pipeline replays them.
  2. fwd_stall = 1: entry[0] holds, entry[1] <= bubble, entry[k] <= entry[k-1] for k >= 2. issue_valid is ignored. flush still discards nothing extra, since entry[0] is the stalled instruction.
  3. Otherwise: entry[k] <= entry[k-1] for k >= 1. entry[0] <= {issue_valid & ~flush, issue_we, issue_rd, issue_class}.
- The entry leaving stage DEPTH is dropped. The regfile is write-before-read, so the ID-stage read covers it.
- stall_cycles increments when fwd_stall & ~stall_in and saturates at 32'hFFFF_FFFF.
- Latency: fwd_sel/fwd_stall are combinational from current state and src_*. There is no input-to-output register.
- Static checks, elaboration-time error:
  - 1 <= LD_READY_STAGE <= DEPTH
  - 1 <= MUL_READY_STAGE <= DEPTH
  - NUM_SRC >= 1
- Reset mid-stall: entries clear asynchronously and fwd_stall drops in the same cycle.

Decomposition:
- Package fwd_types:
  - typedef enum logic [1:0] wb_class_t {WB_NONE, WB_ALU, WB_LOAD, WB_MUL}
  - struct sb_entry_t
  - function ready_at(stage, cls), taking the stage parameters as arguments
- Sub-module fwd_match: one source's priority matcher over entry[1..DEPTH], producing sel and stall. Instantiated NUM_SRC times via generate.

Test Plan:
1. Load-use: issue lw x5 (LOAD), then add x6,x5,x5 (srcs 5,5).
   - With add in EX and lw in stage 1: fwd_stall = 1, stall_cycles = 1.
   - Next cycle (lw in stage 2): fwd_sel = {2,2}, fwd_stall = 0.
2. Youngest wins: addi x3 (ALU) in stage 2, addi x3 (ALU) in stage 1, EX reads x3 -> fwd_sel = 1. Repeat with stage 1 as LOAD x3 -> fwd_stall = 1, even though stage 2 is ready.
3. x0 and unused sources:
   - Stage 1 ALU writing rd = 0, EX src 0 -> fwd_sel = 0, no stall.
   - LOAD x7 in stage 1, src_used = 0 for x7 -> no stall.
4. MUL (MUL_READY_STAGE = 3): mul x9 followed by use of x9.
   - Stall for 2 cycles (mul in stages 1 and 2), then fwd_sel = 3.
   - stall_cycles = 2.
5. stall_in during a load-use stall: entries and stall_cycles frozen for 4 cycles, and fwd_stall stays 1 throughout. Assert flush with issue_valid in a non-stalled cycle -> entry[0] is a bubble and the next-cycle fwd_stall = 0.
6. Async reset (rst low) mid-stall, between clock edges: fwd_stall = 0 and stall_cycles = 0 without waiting for clk. A parameter sweep with DEPTH = 5 and LD_READY_STAGE = 4 must produce a 3-cycle load-use stall.
